// File: rtl/byte_serial_adder_pkg.sv
// Shared definitions for the byte-serial adder: state encoding, byte width
// and the byte-index width helper.
package byte_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index must count 0..NBYTES-1 and still fit the post-increment value.
  function automatic int idx_width(input int nbytes);
    return $clog2(nbytes) + 1;
  endfunction

endpackage

// File: rtl/byte_serial_adder_if.sv
// Request/result bundle of the byte-serial adder. The master drives the
// operands and start; the slave (the adder) returns the registered result.
interface byte_serial_adder_if
  import byte_serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
);

  localparam int W = BYTE_W * NBYTES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b, c_in,
    input  sum, c_out, overflow, busy, done
  );

  modport slave (
    input  start, a, b, c_in,
    output sum, c_out, overflow, busy, done
  );

endinterface

// File: rtl/byte_serial_adder_cla_8bit.sv
// 8-bit carry-lookahead unit: every carry is formed directly from the
// generate/propagate terms and the incoming carry (sum-of-products form).
module cla_8bit (
  input  logic       c_in,
  input  logic [7:0] p,
  input  logic [7:0] g,
  output logic [8:0] c_out
);

  // Build c[j+1] = g[j] | p[j]g[j-1] | ... | p[j..0]c_in for each bit.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop writes it, so no path can leave it unassigned and infer a latch;
    // blocking '=' is correct here because later statements read earlier ones.
    c_out    = '0;
    c_out[0] = c_in;
    for (int j = 0; j < 8; j++) begin
      logic v_carry;
      logic v_prop;
      v_carry = 1'b0;
      v_prop  = 1'b1;
      for (int m = j; m >= 0; m--) begin
        v_carry = v_carry | (v_prop & g[m]);
        v_prop  = v_prop & p[m];
      end
      c_out[j+1] = v_carry | (v_prop & c_in);
    end
  end

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial adder: latches two W-bit operands on start, adds one byte per
// cycle through a single 8-bit CLA, and presents the registered result with
// a one-cycle done pulse after NBYTES cycles.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  byte_serial_adder_if.slave  bus
);

  localparam int                 W        = BYTE_W * NBYTES;
  localparam int                 IDX_W    = idx_width(NBYTES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_work;
  logic               r_carry;
  logic [W-1:0]       r_sum;
  logic               r_c_out;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic [BYTE_W-1:0]  w_a_byte;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_p;
  logic [BYTE_W-1:0]  w_g;
  logic [8:0]         w_c;
  logic [BYTE_W-1:0]  w_sum_byte;
  logic [W-1:0]       w_work_next;
  logic               w_last;

  // Current byte of each latched operand, selected by the byte index.
  assign w_a_byte   = BYTE_W'(r_a >> {r_idx, 3'b000});
  assign w_b_byte   = BYTE_W'(r_b >> {r_idx, 3'b000});
  assign w_p        = w_a_byte ^ w_b_byte;
  assign w_g        = w_a_byte & w_b_byte;
  assign w_sum_byte = w_p ^ w_c[7:0];
  assign w_last     = (r_idx == LAST_IDX);

  cla_8bit u_cla (
    .c_in  (r_carry),
    .p     (w_p),
    .g     (w_g),
    .c_out (w_c)
  );

  // Working sum with the current byte merged in at its position.
  always_comb begin
    w_work_next = r_work;
    for (int j = 0; j < NBYTES; j++) begin
      if (r_idx == IDX_W'(j)) begin
        w_work_next[j*BYTE_W +: BYTE_W] = w_sum_byte;
      end
    end
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand and working-sum registers are reset along with the
    // control state even though they are reloaded on start; it costs nothing
    // here and keeps the block free of X after power-up.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' for all state so every register samples the
      // pre-edge values regardless of statement order.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.c_in;
            r_idx   <= '0;
            r_work  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_work  <= w_work_next;
          r_carry <= w_c[8];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_sum   <= w_work_next;
            r_c_out <= w_c[8];
            r_ovf   <= w_c[7] ^ w_c[8];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sum      = r_sum;
  assign bus.c_out    = r_c_out;
  assign bus.overflow = r_ovf;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
